// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/step/halt controller for the five-stage pipeline.
// Drives PC write, IF/ID hold and ID/EX flush; counts enabled cycles.
module pipeline_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_halt_fetched,
  input  logic                  i_load_use,
  output logic                  o_pc_write,
  output logic                  o_if_id_burbuja,
  output logic                  o_id_ex_flush,
  output logic                  o_pipe_enable,
  output logic                  o_step_done,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_cycle_count
);

  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_WAIT,
    S_STEP_EXEC,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         drain_q, drain_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  halt_eff;

  // A HALT seen during a stall is refetched next cycle, so it is ignored.
  assign halt_eff = i_halt_fetched & ~i_load_use;

  always_comb begin
    state_d         = state_q;
    drain_d         = drain_q;
    o_pc_write      = 1'b0;
    o_if_id_burbuja = 1'b1;
    o_id_ex_flush   = 1'b0;
    o_pipe_enable   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = i_step_mode ? S_STEP_WAIT : S_RUN;
        end
      end
      S_RUN, S_STEP_EXEC: begin
        o_pipe_enable   = 1'b1;
        o_pc_write      = ~i_load_use & ~halt_eff;
        o_if_id_burbuja = i_load_use;
        o_id_ex_flush   = i_load_use;
        if (halt_eff) begin
          state_d = S_DRAIN;
          drain_d = CW'(DRAIN_CYCLES);
        end else if (state_q == S_STEP_EXEC) begin
          state_d = S_STEP_WAIT;
        end
      end
      S_STEP_WAIT: begin
        if (i_step) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_DRAIN: begin
        o_pipe_enable   = 1'b1;
        o_if_id_burbuja = i_load_use;
        o_id_ex_flush   = i_load_use;
        if (drain_q == '0) begin
          state_d = S_HALTED;
        end else if (!i_load_use) begin
          drain_d = drain_q - CW'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = (state_q == S_STEP_EXEC);
    if (o_pipe_enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign o_step_done   = done_q;
  assign o_halted      = (state_q == S_HALTED);
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: vector table, directed sequences and
// random traffic checked against a behavioural model.
module tb_pipeline_sequencer;

  localparam int DW = 32;
  localparam int DC = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, step_mode, step, halt_f, load_use;
  logic pc_write, burbuja, flush, pipe_en, step_done, halted;
  logic [DW-1:0] cnt;
  logic s_pc, s_bur, s_fl, s_pe, s_sd, s_h;
  logic [SW-1:0] s_cnt;

  pipeline_sequencer #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DC)) u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_step_mode(step_mode), .i_step(step), .i_halt_fetched(halt_f),
    .i_load_use(load_use), .o_pc_write(pc_write),
    .o_if_id_burbuja(burbuja), .o_id_ex_flush(flush),
    .o_pipe_enable(pipe_en), .o_step_done(step_done),
    .o_halted(halted), .o_cycle_count(cnt)
  );

  // narrow counter copy exercises saturation
  pipeline_sequencer #(.DATA_WIDTH(SW), .DRAIN_CYCLES(DC)) u_sat (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_step_mode(step_mode), .i_step(step), .i_halt_fetched(halt_f),
    .i_load_use(load_use), .o_pc_write(s_pc),
    .o_if_id_burbuja(s_bur), .o_id_ex_flush(s_fl),
    .o_pipe_enable(s_pe), .o_step_done(s_sd),
    .o_halted(s_h), .o_cycle_count(s_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  logic ob_pc, ob_bur, ob_fl, ob_pe, ob_sd, ob_h;
  logic [DW-1:0] ob_cnt;

  // behavioural model: started/mode flags, armed step, drain countdown
  logic m_valid = 1'b0;
  logic m_started, m_stepmode, m_armed, m_halted, m_done;
  int   m_drain;
  logic [DW-1:0] m_cnt;
  logic [SW-1:0] m_scnt;

  function automatic logic m_active();
    return m_started && !m_halted &&
           (m_drain >= 0 || !m_stepmode || m_armed);
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_check();
    logic act;
    logic [5:0] e, g, gs;
    act = m_active();
    e = {act && m_drain < 0 && !load_use && !halt_f,
         !act || load_use, act && load_use, act, m_done, m_halted};
    g  = {pc_write, burbuja, flush, pipe_en, step_done, halted};
    gs = {s_pc, s_bur, s_fl, s_pe, s_sd, s_h};
    n_chk++;
    if (g !== e || gs !== e || cnt !== m_cnt || s_cnt !== m_scnt) begin
      n_err++;
      $display("FAIL model t=%0t outs=%b narrow=%b exp=%b cnt=%0d exp=%0d narrow_cnt=%0d exp=%0d",
               $time, g, gs, e, cnt, m_cnt, s_cnt, m_scnt);
    end
  endtask

  task automatic model_step(input logic r, st, sm, sp, hf, lu);
    logic act, dn;
    if (!r) begin
      m_valid    = 1'b1;
      m_started  = 1'b0;
      m_stepmode = 1'b0;
      m_armed    = 1'b0;
      m_halted   = 1'b0;
      m_done     = 1'b0;
      m_drain    = -1;
      m_cnt      = '0;
      m_scnt     = '0;
    end else begin
      act = m_active();
      dn  = act && m_stepmode && m_armed && (m_drain < 0);
      if (act) begin
        if (m_cnt != '1) m_cnt = m_cnt + DW'(1);
        if (m_scnt != '1) m_scnt = m_scnt + SW'(1);
      end
      if (!m_started) begin
        if (st) begin
          m_started  = 1'b1;
          m_stepmode = sm;
          m_armed    = 1'b0;
        end
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_drain >= 0) begin
        if (m_drain == 0) m_halted = 1'b1;
        else if (!lu) m_drain = m_drain - 1;
      end else if (m_stepmode && !m_armed) begin
        if (sp) m_armed = 1'b1;
      end else begin
        if (hf && !lu) m_drain = DC;
        m_armed = 1'b0;
      end
      m_done = dn;
    end
  endtask

  task automatic cyc(input logic r, st, sm, sp, hf, lu);
    rst_n = r; start = st; step_mode = sm;
    step = sp; halt_f = hf; load_use = lu;
    @(negedge clk);
    ob_pc = pc_write; ob_bur = burbuja; ob_fl = flush;
    ob_pe = pipe_en; ob_sd = step_done; ob_h = halted; ob_cnt = cnt;
    if (m_valid) model_check();
    @(posedge clk);
    model_step(r, st, sm, sp, hf, lu);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic r, st, sm, sp, hf, lu;
    logic [5:0] eo;  // pc, burbuja, flush, pipe_en, step_done, halted
    int ec;
  } vec_t;

  vec_t tv[15];

  initial begin
    int pc_ones, rise, pe_n, sd_n, mism, hseen;
    logic prev_pe;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000, 0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b010000, 0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100100, 0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011100, 1};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100100, 2};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011100, 3};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000100, 4};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 5};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b011100, 6};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 7};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 8};
    tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 9};
    tv[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100, 10};
    tv[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010001, 11};
    tv[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010001, 11};

    // table: reset, load-use in RUN, HALT under stall, stall in DRAIN
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tv[i].r, tv[i].st, tv[i].sm, tv[i].sp, tv[i].hf, tv[i].lu);
      n_chk++;
      if ({ob_pc, ob_bur, ob_fl, ob_pe, ob_sd, ob_h} !== tv[i].eo ||
          ob_cnt !== DW'(tv[i].ec)) begin
        n_err++;
        $display("FAIL vec%0d: outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                 i, {ob_pc, ob_bur, ob_fl, ob_pe, ob_sd, ob_h}, ob_cnt,
                 tv[i].eo, tv[i].ec);
      end
    end

    // continuous run, HALT ten cycles after start
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pc", ob_pc, 0);
    chk("reset_burbuja", ob_bur, 1);
    chk("reset_pipe_en", ob_pe, 0);
    chk("reset_cnt", ob_cnt, 0);
    chk("reset_halted", ob_h, 0);
    pc_ones = 0;
    for (int i = 0; i < 10; i++) begin
      idle_cyc();
      pc_ones += int'(ob_pc);
    end
    chk("run_pc_ones", pc_ones, 10);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_cycle_pc", ob_pc, 0);
    rise = -1;
    for (int k = 1; k <= 20; k++) begin
      idle_cyc();
      if (ob_h) begin
        rise = k;
        break;
      end
    end
    chk("halt_latency", rise, 6);
    chk("run_cnt", ob_cnt, 16);
    for (int i = 0; i < 3; i++) idle_cyc();
    chk("halted_cnt_frozen", ob_cnt, 16);
    chk("halted_sticky", ob_h, 1);

    // step mode: three steps five cycles apart
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("step_idle_ignored", ob_pe, 0);
    pe_n = 0; sd_n = 0; mism = 0; prev_pe = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 5; j++) begin
        cyc(1'b1, 1'b0, 1'b0, (j == 0), 1'b0, 1'b0);
        pe_n += int'(ob_pe);
        sd_n += int'(ob_sd);
        if (ob_sd != prev_pe) mism++;
        prev_pe = ob_pe;
      end
    end
    chk("step_active_cycles", pe_n, 3);
    chk("step_done_pulses", sd_n, 3);
    chk("step_done_align", mism, 0);
    chk("step_cnt", ob_cnt, 3);

    // reset in the second DRAIN cycle, then a fresh run
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_drain_pipe_en", ob_pe, 1);
    idle_cyc();
    chk("abort_pipe_en", ob_pe, 0);
    chk("abort_cnt", ob_cnt, 0);
    chk("abort_burbuja", ob_bur, 1);
    hseen = 0;
    for (int i = 0; i < 8; i++) begin
      idle_cyc();
      hseen += int'(ob_h);
    end
    chk("abort_no_halt", hseen, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    chk("restart_pc", ob_pc, 1);
    idle_cyc();
    chk("restart_pc2", ob_pc, 1);
    chk("restart_cnt", ob_cnt, 1);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 39) != 0),
          ($urandom_range(0, 7) == 0),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Execution controller for the five-stage MIPS pipeline. It drives the PC write enable, the IF/ID hold (`burbuja`) line and the ID/EX flush, and sequences the pipeline through start, continuous run, single-step, halt drain and halted states. It also resolves load-use stalls reported by the hazard detector and keeps a cycle counter for the debug unit. It sits between the debug unit / hazard detector and the IF stage, the IF/ID register and the ID/EX register.

## Interface
- `DATA_WIDTH`, 32: width of `o_cycle_count`.
- `DRAIN_CYCLES`, 4: number of non-stalled cycles run after a HALT fetch so that HALT reaches WB.
- `i_clock` input 1: single clock; all state updates on its rising edge.
- `i_reset` input 1: synchronous, active-low reset; `i_reset == 0` at a rising edge resets the block.
- `i_start` input 1: single-cycle pulse from the debug unit that leaves IDLE.
- `i_step_mode` input 1: sampled only on the `i_start` cycle; 1 selects step mode, 0 selects continuous run.
- `i_step` input 1: single-cycle pulse; advances the pipeline by one cycle while in STEP_WAIT.
- `i_halt_fetched` input 1: the instruction currently leaving IF is HALT.
- `i_load_use` input 1: load-use hazard flag from the hazard detector for the current cycle.
- `o_pc_write` output 1: PC register load enable.
- `o_if_id_burbuja` output 1: 1 makes IF/ID hold its contents.
- `o_id_ex_flush` output 1: 1 makes ID/EX load a NOP.
- `o_pipe_enable` output 1: enable for ID/EX, EX/MEM and MEM/WB.
- `o_step_done` output 1: registered one-cycle pulse after each executed step.
- `o_halted` output 1: pipeline fully drained after HALT.
- `o_cycle_count` output DATA_WIDTH: number of enabled cycles, saturating.

## Operation
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED.
- **Frozen state outputs.** In IDLE, STEP_WAIT and HALTED the pipeline is frozen:
  - `o_pc_write=0`, `o_if_id_burbuja=1`, `o_id_ex_flush=0`, `o_pipe_enable=0`.
- **Active state outputs.** In RUN and STEP_EXEC the pipeline is active:
  - `o_pipe_enable=1`
  - `o_pc_write=!i_load_use`
  - `o_if_id_burbuja=i_load_use`
  - `o_id_ex_flush=i_load_use`
- **DRAIN outputs.**
  - `o_pipe_enable=1`, `o_pc_write=0`.
  - `o_if_id_burbuja=i_load_use`, `o_id_ex_flush=i_load_use`.
- **Effective HALT.** `halt_eff = i_halt_fetched & !i_load_use`. A HALT fetched during a stall is ignored because it is refetched on the next cycle.
- **Transitions:**
  - IDLE: `i_start` goes to STEP_WAIT if `i_step_mode=1`, otherwise to RUN. `i_step` is ignored in IDLE, including on the same cycle as `i_start`.
  - RUN: `halt_eff` goes to DRAIN, with the drain counter loaded to `DRAIN_CYCLES`. `o_pc_write` is 0 in that cycle (PC frozen on HALT). Otherwise stay in RUN.
  - STEP_WAIT: `i_step` goes to STEP_EXEC. `i_start` is ignored.
  - STEP_EXEC (always exactly one cycle): `halt_eff` goes to DRAIN, with `o_pc_write=0` in that cycle. Otherwise go to STEP_WAIT. In both cases `o_step_done` pulses on the next cycle.
  - DRAIN: the counter decrements on each cycle where `i_load_use=0` and holds while `i_load_use=1`. Move to HALTED on the cycle after the counter reaches 0. Step mode does not pause the drain.
  - HALTED: absorbing. Only reset leaves it. `o_halted=1`.
- **Stalls in step mode.** A stall cycle inside STEP_EXEC still consumes the step.
- **Cycle counter.** `o_cycle_count` increments on every cycle where `o_pipe_enable=1` and saturates at `{DATA_WIDTH{1'b1}}`. It is not cleared on HALT.
- **Drain counter width.** `$clog2(DRAIN_CYCLES+1)` bits.

## Timing
- Reset (`i_reset=0` at a rising edge) sets:
  - state = IDLE, drain counter = 0, `o_cycle_count=0`, `o_step_done=0`.
  - Outputs therefore settle at `o_pc_write=0`, `o_if_id_burbuja=1`, `o_id_ex_flush=0`, `o_pipe_enable=0`, `o_halted=0`.
  - Reset mid-RUN, mid-DRAIN or mid-step aborts the operation immediately.
- State, the drain counter, `o_cycle_count` and `o_step_done` are registered. The other outputs are combinational from state and `i_load_use`, so the stall response has zero latency.
- Latencies:
  - `i_start` at edge N puts the block in RUN in cycle N+1; the first PC write happens at edge N+1.
  - `i_step` at edge N gives one active cycle N+1; `o_step_done=1` in cycle N+2.
  - A HALT fetched in cycle H with no stalls gives DRAIN in cycles H+1 through H+DRAIN_CYCLES+1, then `o_halted=1` from cycle H+DRAIN_CYCLES+2.

## Test plan
- **Reset:** hold `i_reset=0` for 2 cycles, then release → `o_pc_write=0`, `o_if_id_burbuja=1`, `o_pipe_enable=0`, `o_cycle_count=0`, `o_halted=0`.
- **Continuous run:** `i_start` with `i_step_mode=0`, HALT fetched 10 cycles later → `o_pc_write=1` for 10 cycles, then 0. `o_halted` rises 6 cycles after the HALT cycle (DRAIN_CYCLES=4). `o_cycle_count` freezes at 16.
- **Load-use in RUN:** `i_load_use=1` for 1 cycle → in that cycle `o_pc_write=0`, `o_if_id_burbuja=1`, `o_id_ex_flush=1`. Next cycle returns to 1/0/0.
- **Step mode:** `i_start` with `i_step_mode=1`, then 3 `i_step` pulses spaced 5 cycles apart → exactly 3 cycles with `o_pipe_enable=1`, 3 `o_step_done` pulses each one cycle after its active cycle, `o_cycle_count=3`.
- **HALT with stall:** `i_halt_fetched=1` together with `i_load_use=1` → no DRAIN entry in that cycle. HALT on the next clean cycle enters DRAIN. A stall inside DRAIN delays `o_halted` by 1 cycle.
- **Reset mid-drain:** `i_reset=0` in the second DRAIN cycle → IDLE, `o_cycle_count=0`, `o_halted` stays 0. A subsequent `i_start` runs normally.
